uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester packet arbiter in front of a UART transmitter core: round-robin packet locking,
// one-cycle gap after each byte, and deferred baud changes. Optional lock timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int BAUDBITS  = 9,
    parameter int BAUD_INIT = 26,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    input  logic        cfg_wr,
    input  logic [15:0] cfg_baud,
    output logic        cfg_busy,
    output logic [1:0]  gnt,
    output logic [15:0] uart_d,
    output logic        uart_wrtx,
    output logic        uart_wrbaud,
    input  logic        uart_thre,
    input  logic        uart_tend
);

    typedef enum logic [2:0] {INIT, IDLE, LOCK, GAP, CFG} state_t;

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  rr_q, rr_d;          // 1: requester 1 wins a tie
    logic                  cfg_busy_q, cfg_busy_d;
    logic [BAUDBITS-1:0]   cfg_val_q, cfg_val_d;
    logic                  last_q, last_d;
    logic                  sel_valid, sel_last;
    logic [7:0]            sel_data;
    logic                  unused_cfg;

    assign unused_cfg = ^cfg_baud;
    assign sel_valid  = gnt_q[1] ? req1_valid : req0_valid;
    assign sel_data   = gnt_q[1] ? req1_data  : req0_data;
    assign sel_last   = gnt_q[1] ? req1_last  : req0_last;
    assign gnt        = gnt_q;
    assign cfg_busy   = cfg_busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cfg_busy_d  = cfg_busy_q;
        cfg_val_d   = cfg_val_q;
        last_d      = last_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        uart_wrtx   = 1'b0;
        uart_wrbaud = 1'b0;
        uart_d      = 16'h0000;

        if (cfg_wr) begin
            cfg_val_d  = cfg_baud[BAUDBITS-1:0];
            cfg_busy_d = 1'b1;
        end

        case (state_q)
            INIT: begin
                uart_wrbaud             = 1'b1;
                uart_d[BAUDBITS-1:0]    = BAUDBITS'(BAUD_INIT);
                state_d                 = IDLE;
            end
            IDLE: begin
                // A pending baud change blocks new grants until the line drains.
                if (cfg_busy_q) begin
                    if (uart_tend) state_d = CFG;
                end else if (req0_valid && (!req1_valid || !rr_q)) begin
                    gnt_d   = 2'b01;
                    rr_d    = 1'b1;
                    state_d = LOCK;
                end else if (req1_valid) begin
                    gnt_d   = 2'b10;
                    rr_d    = 1'b0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req0_ready = gnt_q[0] & uart_thre;
                req1_ready = gnt_q[1] & uart_thre;
                if (sel_valid && uart_thre) begin
                    uart_wrtx = 1'b1;
                    uart_d    = {8'h00, sel_data};
                    last_d    = sel_last;
                    state_d   = GAP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_q == 8'(TIMEOUT)) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end
`endif
            end
            GAP: begin
                if (last_q) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            CFG: begin
                uart_wrbaud          = 1'b1;
                uart_d[BAUDBITS-1:0] = cfg_val_q;
                if (!cfg_wr) cfg_busy_d = 1'b0;
                state_d              = IDLE;
            end
            default: state_d = INIT;
        endcase

        // Strobes stay quiet while reset is held; INIT fires on the first free cycle.
        if (rst) begin
            req0_ready  = 1'b0;
            req1_ready  = 1'b0;
            uart_wrtx   = 1'b0;
            uart_wrbaud = 1'b0;
            uart_d      = 16'h0000;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_comb begin
        tmo_d = 8'h00;
        if (state_q == LOCK && state_d == LOCK && !sel_valid)
            tmo_d = (tmo_q == 8'(TIMEOUT)) ? tmo_q : tmo_q + 8'h01;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            gnt_q      <= 2'b00;
            rr_q       <= 1'b0;
            cfg_busy_q <= 1'b0;
            cfg_val_q  <= '0;
            last_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            cfg_busy_q <= cfg_busy_d;
            cfg_val_q  <= cfg_val_d;
            last_q     <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: reset/INIT baud write, packet ordering, round-robin,
// thre stall, deferred baud change, lock hold (or timeout with UART_ARB_TIMEOUT_EN), reset mid-packet.
module tb_uart_tx_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req0_last = 0, req0_ready;
    logic        req1_valid = 0, req1_last = 0, req1_ready;
    logic [7:0]  req0_data = 0, req1_data = 0;
    logic        cfg_wr = 0, cfg_busy;
    logic [15:0] cfg_baud = 0, uart_d;
    logic [1:0]  gnt;
    logic        uart_wrtx, uart_wrbaud;
    logic        uart_thre = 1, uart_tend = 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] d0[4], d1[4], ex[5];
    logic       l0[4], l1[4];
    int         n0, n1, ne;
    logic [7:0] got[$];

    uart_tx_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .cfg_busy(cfg_busy), .gnt(gnt),
        .uart_d(uart_d), .uart_wrtx(uart_wrtx), .uart_wrbaud(uart_wrbaud),
        .uart_thre(uart_thre), .uart_tend(uart_tend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesters present d0/d1 in order, advancing on valid&ready; every wrtx byte is collected.
    task automatic run_xfer(input string tag, input int max_cyc);
        int i0 = 0, i1 = 0, b2b = 0, both = 0, cyc = 0;
        bit prev = 0;
        got.delete();
        while ((i0 < n0 || i1 < n1) && cyc < max_cyc) begin
            @(negedge clk);
            req0_valid = (i0 < n0); req0_data = d0[i0]; req0_last = l0[i0];
            req1_valid = (i1 < n1); req1_data = d1[i1]; req1_last = l1[i1];
            #1;
            if (uart_wrtx && uart_wrbaud) both++;
            if (uart_wrtx && prev) b2b++;
            prev = uart_wrtx;
            if (uart_wrtx) got.push_back(uart_d[7:0]);
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
            cyc++;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk({tag, "_done"}, {31'd0, (i0 == n0 && i1 == n1)}, 32'd1);
        chk({tag, "_b2b"}, b2b, 0);
        chk({tag, "_wr_both"}, both, 0);
        chk({tag, "_count"}, got.size(), ne);
        for (int k = 0; k < ne; k++) chk($sformatf("%s_byte%0d", tag, k), got[k], ex[k]);
    endtask

    initial begin
        int err;
        bit sw;

        // reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_wrbaud", uart_wrbaud, 0);
        chk("rst_wrtx", uart_wrtx, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_busy", cfg_busy, 0);
        @(negedge clk); rst = 0; #1;
        chk("init_wrbaud", uart_wrbaud, 1);
        chk("init_d", uart_d, 16'h001A);
        @(negedge clk); #1;
        chk("init_once", uart_wrbaud, 0);

        // two packets, both requesters valid
        d0 = '{8'h41, 8'h42, 8'h43, 8'h00}; l0 = '{1'b0, 1'b0, 1'b1, 1'b0}; n0 = 3;
        d1 = '{8'h61, 8'h62, 8'h00, 8'h00}; l1 = '{1'b0, 1'b1, 1'b0, 1'b0}; n1 = 2;
        ex = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62}; ne = 5;
        run_xfer("pkt", 60);

        // round-robin: requester 1 wins the tie after requester 0 was served
        d0 = '{8'h10, 8'h11, 8'h00, 8'h00}; l0 = '{1'b1, 1'b1, 1'b0, 1'b0}; n0 = 2;
        d1 = '{8'h20, 8'h00, 8'h00, 8'h00}; l1 = '{1'b1, 1'b0, 1'b0, 1'b0}; n1 = 1;
        ex = '{8'h10, 8'h20, 8'h11, 8'h00, 8'h00}; ne = 3;
        run_xfer("rr", 60);

        // thre stall
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h55; req0_last = 1; uart_thre = 0;
        #1;
        err = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (req0_ready || uart_wrtx) err++;
        end
        chk("stall_quiet", err, 0);
        chk("stall_gnt", gnt, 2'b01);
        @(negedge clk); uart_thre = 1; #1;
        chk("stall_ready", req0_ready, 1);
        chk("stall_wrtx", uart_wrtx, 1);
        chk("stall_d", uart_d, 16'h0055);
        @(negedge clk); req0_valid = 0; #1;
        chk("stall_gap", uart_wrtx, 0);
        @(negedge clk); #1;
        chk("stall_release", gnt, 0);

        // baud change deferred until packet end and tend=1
        @(negedge clk);
        req1_valid = 1; req1_data = 8'h71; req1_last = 0; uart_tend = 0;
        @(negedge clk); cfg_wr = 1; cfg_baud = 16'h0050; #1;
        chk("cfg_wr71", {uart_wrtx, uart_d}, {1'b1, 16'h0071});
        @(negedge clk); cfg_wr = 0; req1_data = 8'h72; #1;
        chk("cfg_busy1", cfg_busy, 1);
        chk("cfg_gap_rdy", req1_ready, 0);
        @(negedge clk); cfg_wr = 1; cfg_baud = 16'h0064; #1;
        chk("cfg_wr72", {uart_wrtx, uart_d}, {1'b1, 16'h0072});
        @(negedge clk); cfg_wr = 0; req1_data = 8'h73; req1_last = 1; #1;
        chk("cfg_gap2_baud", uart_wrbaud, 0);
        @(negedge clk); #1;
        chk("cfg_wr73", {uart_wrtx, uart_d}, {1'b1, 16'h0073});
        chk("cfg_mid_baud", uart_wrbaud, 0);
        @(negedge clk); req1_valid = 0; #1;
        chk("cfg_busy2", cfg_busy, 1);
        @(negedge clk); req0_valid = 1; req0_data = 8'hEE; req0_last = 1; #1;
        chk("cfg_tend0", uart_wrbaud, 0);
        @(negedge clk); uart_tend = 1; #1;
        chk("cfg_nogrant", gnt, 0);
        chk("cfg_wait_baud", uart_wrbaud, 0);
        @(negedge clk); req0_valid = 0; #1;
        chk("cfg_wrbaud", uart_wrbaud, 1);
        chk("cfg_d", uart_d, 16'h0064);
        chk("cfg_no_wrtx", uart_wrtx, 0);
        @(negedge clk); #1;
        chk("cfg_busy_clr", cfg_busy, 0);
        chk("cfg_one_pulse", uart_wrbaud, 0);

        // requester 0 stalls mid-packet while requester 1 waits
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h31; req0_last = 0;
        req1_valid = 1; req1_data = 8'h91; req1_last = 0;
        @(negedge clk); #1;
        chk("hold_wr31", {uart_wrtx, uart_d}, {1'b1, 16'h0031});
        chk("hold_gnt", gnt, 2'b01);
        @(negedge clk); req0_valid = 0;
        err = 0; sw = 0;
        for (int k = 0; k < 300 && !sw; k++) begin
            @(negedge clk); #1;
`ifdef UART_ARB_TIMEOUT_EN
            if (gnt == 2'b10 && uart_wrtx) sw = 1;
`else
            if (gnt != 2'b01 || uart_wrtx) err++;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("tmo_switch", sw, 1);
`else
        chk("hold_idle", err, 0);
        @(negedge clk); req0_valid = 1; req0_data = 8'h32; req0_last = 1; #1;
        chk("hold_wr32", {uart_wrtx, uart_d}, {1'b1, 16'h0032});
        @(negedge clk); req0_valid = 0;
        @(negedge clk);
        @(negedge clk); #1;
`endif
        chk("wr91", {uart_wrtx, uart_d, gnt}, {1'b1, 16'h0091, 2'b10});

        // reset one cycle after a write; the accepted byte is not re-sent
        @(negedge clk); req1_data = 8'h92; rst = 1; #1;
        chk("rst2_wrtx", uart_wrtx, 0);
        @(negedge clk); rst = 0; #1;
        chk("rst2_gnt", gnt, 0);
        chk("rst2_init", {uart_wrbaud, uart_d}, {1'b1, 16'h001A});
        chk("rst2_no_wrtx", uart_wrtx, 0);
        @(negedge clk); #1;
        chk("rst2_idle", {uart_wrtx, req1_ready, gnt}, 0);
        @(negedge clk); #1;
        chk("rst2_next", {uart_wrtx, uart_d}, {1'b1, 16'h0092});
        req1_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
